// File: rtl/pixel_mem_pkg.sv
// Shared types and defaults for the pixel buffer command interface.
// Imported by both the initiator-side arbiter and the memory responder.
package pixel_mem_pkg;

  localparam int unsigned PixAddrW = 8;
  localparam int unsigned PixDataW = 8;
  localparam int unsigned LatCntW  = 4;

  typedef enum logic [1:0] {
    INSTR_NONE    = 2'b00,
    INSTR_READ    = 2'b01,
    INSTR_WRITE   = 2'b10,
    INSTR_ILLEGAL = 2'b11
  } instr_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10
  } resp_state_t;

endpackage

// File: rtl/pixel_store.sv
// Single-port pixel RAM: synchronous write, registered read.
// Only the read register is reset; array contents survive reset.
module pixel_store
  import pixel_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = PixAddrW,
  parameter int unsigned DATA_W = PixDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pixel_mem_responder.sv
// Memory-side responder: captures one command at a time, holds busy for the
// configured latency, then commits the write or returns the read data.
module pixel_mem_responder
  import pixel_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = PixAddrW,
  parameter int unsigned DATA_W    = PixDataW,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        instruction,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  output logic              busy,
  output logic [DATA_W-1:0] data_r,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              cmd_err
);

  resp_state_t         state_q, state_d;
  logic [LatCntW-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_ack_q, wr_ack_d;
  logic                cmd_err_q, cmd_err_d;
  logic                store_we, store_re;
  instr_t              instr;

  assign instr = instr_t'(instruction);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    cmd_err_d  = 1'b0;
    store_we   = 1'b0;
    store_re   = 1'b0;
    unique case (state_q)
      StIdle: begin
        unique case (instr)
          INSTR_READ: begin
            addr_d  = addr_r;
            cnt_d   = LatCntW'(READ_LAT - 1);
            state_d = StRead;
          end
          INSTR_WRITE: begin
            addr_d  = addr_w;
            data_d  = data_w;
            cnt_d   = LatCntW'(WRITE_LAT - 1);
            state_d = StWrite;
          end
          INSTR_ILLEGAL: cmd_err_d = 1'b1;
          INSTR_NONE:    ;
        endcase
      end
      StRead: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LatCntW'(1);
        end else begin
          // Store's registered read lands on the same edge as rd_valid.
          store_re   = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StWrite: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LatCntW'(1);
        end else begin
          store_we = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  pixel_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .clk  (clk),
    .rst  (rst),
    .we   (store_we),
    .re   (store_re),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(data_r)
  );

  assign busy     = (state_q != StIdle);
  assign rd_valid = rd_valid_q;
  assign wr_ack   = wr_ack_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Bench for pixel_mem_responder: directed cases on the default latencies plus
// randomized traffic on three latency configurations against an array model.
module tb_pixel_mem_responder;

  localparam int NDut = 3;

  logic       clk;
  logic       rst      [NDut];
  logic [1:0] instr    [NDut];
  logic [7:0] addr_r   [NDut];
  logic [7:0] addr_w   [NDut];
  logic [7:0] data_w   [NDut];
  logic       busy     [NDut];
  logic [7:0] data_r   [NDut];
  logic       rd_valid [NDut];
  logic       wr_ack   [NDut];
  logic       cmd_err  [NDut];

  int rlat [NDut] = '{2, 1, 15};
  int wlat [NDut] = '{1, 2, 15};

  logic [7:0] mem_m   [NDut][256];
  logic [7:0] last_rd [NDut];

  int n_vec = 0;
  int n_err = 0;

  pixel_mem_responder u_dut0 (
    .clk(clk), .rst(rst[0]), .instruction(instr[0]), .addr_r(addr_r[0]),
    .addr_w(addr_w[0]), .data_w(data_w[0]), .busy(busy[0]), .data_r(data_r[0]),
    .rd_valid(rd_valid[0]), .wr_ack(wr_ack[0]), .cmd_err(cmd_err[0])
  );

  pixel_mem_responder #(.READ_LAT(1), .WRITE_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .instruction(instr[1]), .addr_r(addr_r[1]),
    .addr_w(addr_w[1]), .data_w(data_w[1]), .busy(busy[1]), .data_r(data_r[1]),
    .rd_valid(rd_valid[1]), .wr_ack(wr_ack[1]), .cmd_err(cmd_err[1])
  );

  pixel_mem_responder #(.READ_LAT(15), .WRITE_LAT(15)) u_dut2 (
    .clk(clk), .rst(rst[2]), .instruction(instr[2]), .addr_r(addr_r[2]),
    .addr_w(addr_w[2]), .data_w(data_w[2]), .busy(busy[2]), .data_r(data_r[2]),
    .rd_valid(rd_valid[2]), .wr_ack(wr_ack[2]), .cmd_err(cmd_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [1:0] ins, input logic [7:0] ar,
                        input logic [7:0] aw, input logic [7:0] dw);
    instr[k]  = ins;
    addr_r[k] = ar;
    addr_w[k] = aw;
    data_w[k] = dw;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge busy falls.
  task automatic do_op(input int k, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, input bit junk);
    int n;
    int lat;
    lat = wr ? wlat[k] : rlat[k];
    if (wr) set_in(k, 2'b10, 8'($urandom), a, d);
    else    set_in(k, 2'b01, a, 8'($urandom), 8'($urandom));
    @(negedge clk);
    n = 0;
    while (busy[k] === 1'b1 && n < 40) begin
      chk("busy_no_pulse", {29'd0, rd_valid[k], wr_ack[k], cmd_err[k]}, 32'd0);
      n++;
      if (junk) set_in(k, 2'($urandom), 8'h20, 8'($urandom), 8'($urandom));
      else      set_in(k, 2'b00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
    end
    set_in(k, 2'b00, 8'h00, 8'h00, 8'h00);
    chk(wr ? "wr_busy_len" : "rd_busy_len", n, lat);
    chk("done_pulse", {29'd0, rd_valid[k], wr_ack[k], cmd_err[k]},
        wr ? 32'd2 : 32'd4);
    if (wr) mem_m[k][a] = d;
    else    last_rd[k] = mem_m[k][a];
    chk("data_r", {24'd0, data_r[k]}, {24'd0, last_rd[k]});
  endtask

  task automatic idle(input int k, input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      chk("idle_flags", {28'd0, busy[k], rd_valid[k], wr_ack[k], cmd_err[k]}, 32'd0);
      chk("data_r_hold", {24'd0, data_r[k]}, {24'd0, last_rd[k]});
    end
  endtask

  task automatic illegal(input int k);
    set_in(k, 2'b11, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    set_in(k, 2'b00, 8'h00, 8'h00, 8'h00);
    chk("cmd_err_pulse", {30'd0, busy[k], cmd_err[k]}, 32'd1);
    @(negedge clk);
    chk("cmd_err_clear", {30'd0, busy[k], cmd_err[k]}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NDut; k++) begin
      rst[k] = 1'b1;
      set_in(k, 2'b00, 8'h00, 8'h00, 8'h00);
      last_rd[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDut; k++) begin
      chk("reset_flags", {28'd0, busy[k], rd_valid[k], wr_ack[k], cmd_err[k]}, 32'd0);
      chk("reset_data_r", {24'd0, data_r[k]}, 32'd0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    // Directed sequence on the default-latency instance.
    do_op(0, 1'b1, 8'h10, 8'hA5, 1'b0);
    do_op(0, 1'b0, 8'h10, 8'h00, 1'b0);
    idle(0, 5);
    do_op(0, 1'b1, 8'hFF, 8'h3C, 1'b0);
    do_op(0, 1'b0, 8'hFF, 8'h00, 1'b0);
    do_op(0, 1'b1, 8'h00, 8'h00, 1'b0);
    do_op(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(0, 2'b10, 8'h00, 8'h40, 8'h12);
    @(negedge clk);
    set_in(0, 2'b01, 8'h20, 8'h00, 8'h00);
    @(negedge clk);
    set_in(0, 2'b00, 8'h00, 8'h00, 8'h00);
    mem_m[0][8'h40] = 8'h12;
    chk("ignored_read", {30'd0, busy[0], rd_valid[0]}, 32'd0);
    idle(0, 2);
    illegal(0);

    // Reset during a pending write must discard it.
    set_in(0, 2'b10, 8'h00, 8'h40, 8'h77);
    @(negedge clk);
    chk("write_busy", {31'd0, busy[0]}, 32'd1);
    rst[0] = 1'b1;
    set_in(0, 2'b00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_data_r", {24'd0, data_r[0]}, 32'd0);
    last_rd[0] = 8'h00;
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    do_op(0, 1'b0, 8'h40, 8'h00, 1'b0);

    // Randomized traffic across all latency configurations.
    for (int k = 0; k < NDut; k++) begin
      for (int a = 0; a < 16; a++) do_op(k, 1'b1, 8'(a), 8'($urandom), 1'b0);
      for (int i = 0; i < 100; i++) begin
        do_op(k, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(1, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
